ifetch_buffer: RTL and testbench
================================

Name: ifetch_buffer

Overview:
- Instruction-fetch stage that sits directly downstream of the program-counter register.
- Accepts fetch PCs over a valid/ready handshake and issues word requests to instruction memory, which has variable latency and returns responses in order.
- Pairs each returned instruction with its PC and PC+4 in an in-order buffer, then presents them to decode over a valid/ready handshake.
- Supports a pipeline flush (branch/jump redirect) that discards all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2. Pointer width is log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_in  in  32  fetch address from PC stage
- pc_valid  in  1  pc_in is valid
- pc_ready  out  1  pc_in accepted this cycle
- flush  in  1  redirect: discard all buffered/in-flight fetches
- imem_req  out  1  instruction memory request
- imem_addr  out  32  word address, equal to {pc_in[31:2],2'b00}
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  in-order read response valid
- imem_rdata  in  32  read response data
- dec_valid  out  1  head entry holds a complete instruction
- dec_ready  in  1  decode accepts head entry
- dec_instr  out  32  instruction word of head entry
- dec_pc  out  32  PC of head entry
- dec_pc4  out  32  PC+4 of head entry, modulo 2^32
- dec_misalign  out  1  pc_in[1:0] was non-zero for head entry

Behaviour:
- Reset: behaviour on reset
  - reset is synchronous, active-high; clock clk.
  - Clears all pointers, count, drop_cnt and every entry's valid/filled bits.
  - Clears the storage of dec_instr, dec_pc, dec_pc4 and dec_misalign to 0.
  - dec_valid is 0; imem_req and pc_ready are held 0 while reset is high.
  - Reset mid-operation discards everything; later responses from requests issued before reset are not tracked.
- Entry state: each entry holds {valid, filled, pc, pc4, misalign, instr}.
- Pointers: wr_ptr (allocate), fill_ptr (next response), rd_ptr (head). count is the number of valid entries, range 0..DEPTH.
- Issue condition: can_issue = !reset & !flush & (count < DEPTH) & (drop_cnt == 0), using registered count.
  - Popping and allocating in the same cycle while full is therefore not allowed.
- Request handshake: imem_req = pc_valid & can_issue, and pc_ready = can_issue & imem_gnt. Both are combinational.
- Allocation (pc_valid & pc_ready):
  - Write pc_in, pc_in+32'd4 and (pc_in[1:0]!=0) at wr_ptr.
  - Set valid=1, filled=0; increment wr_ptr with wrap.
- Fill: when imem_rvalid & drop_cnt==0, write imem_rdata to instr at fill_ptr, set filled=1, and increment fill_ptr with wrap.
  - A response with no pending entry cannot occur (protocol guarantee); the bench flags it as an error.
- Drop: when imem_rvalid & drop_cnt!=0, the response is discarded and drop_cnt decrements.
- Output: dec_valid = valid & filled at rd_ptr. The dec_* outputs are driven from the rd_ptr entry.
  - A response at cycle N appears at dec_valid no earlier than N+1.
  - Minimum latency is grant at T, rvalid at T+1, dec_valid at T+2.
- Pop: when dec_valid & dec_ready, clear valid at rd_ptr and increment rd_ptr with wrap.
- count update: +1 on allocate, -1 on pop; both in the same cycle leaves it unchanged.
- Flush cycle:
  - No allocation that cycle, since imem_req is forced to 0.
  - All entries are invalidated and all pointers and count are set to 0.
  - drop_cnt is loaded with (allocated-but-unfilled entries) minus 1 if imem_rvalid is high that cycle, because that response is discarded.
  - A pop in the flush cycle is ignored; dec_valid is not gated by flush, so decode must treat flush as a squash.
- While drop_cnt != 0: no new issue. Responses are consumed only to decrement drop_cnt.
- drop_cnt width is log2(DEPTH)+1.
- Wrap: all pointers wrap from DEPTH-1 to 0; dec_pc4 wraps 32'hFFFFFFFC to 32'h00000000.

Test Plan:
- Single fetch: pc_in=0x100, gnt immediate, rvalid 1 cycle later with 0x00500093 -> dec_valid 2 cycles after grant with dec_instr=0x00500093, dec_pc=0x100, dec_pc4=0x104, dec_misalign=0.
- Backpressure/full: DEPTH=4, dec_ready=0, 6 consecutive PCs 0x0,0x4,… -> exactly 4 grants, then pc_ready=0. Releasing dec_ready drains entries in order 0x0..0xC, after which issue resumes with 0x10.
- Variable latency: gnt delays of 0/3 cycles and rvalid gaps of 0–5 cycles over 20 PCs -> decode sequence matches issue order, with no duplicates or losses.
- Flush with in-flight: 3 requests granted, 1 response returned, flush asserted while a second response arrives in the same cycle -> dec_valid=0 next cycle, drop_cnt=1. The next response is dropped, then a new PC 0x200 is issued and delivered.
- Edge values: pc_in=0xFFFFFFFC yields dec_pc4=0x0. pc_in=0x102 yields imem_addr=0x100 and dec_misalign=1.
- Reset mid-stream: reset for 1 cycle with 2 buffered and 1 in-flight -> all outputs 0 next cycle, and fresh fetches afterwards behave as in the single-fetch scenario.

Source files
------------

// File: rtl/ifetch_if.sv
// ifetch_if: bundles the fetch-stage handshakes of ifetch_buffer.
//   PC side     : pc_in, pc_valid (to buffer), pc_ready (from buffer), flush
//   Memory side : imem_req, imem_addr (from buffer); imem_gnt, imem_rvalid,
//                 imem_rdata (to buffer)
//   Decode side : dec_valid, dec_instr, dec_pc, dec_pc4, dec_misalign (from
//                 buffer); dec_ready (to buffer)
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface ifetch_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;
    logic        dec_misalign;

    modport slave (
        input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output pc_ready, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc4,
               dec_misalign
    );

    modport master (
        output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  pc_ready, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc4,
               dec_misalign
    );
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction-fetch stage between the PC register and decode.
// Accepts fetch PCs, issues word requests to an in-order, variable-latency
// instruction memory, pairs each response with its PC / PC+4 / misalign flag
// in a DEPTH-entry in-order buffer and presents the head entry to decode.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - ifetch_if.slave carrying the PC, memory and decode handshakes
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. pc_ready/imem_gnt form the PC-to-memory transfer
// (imem_req = pc_valid & can_issue, pc_ready = can_issue & imem_gnt), and
// dec_valid/dec_ready form the head-to-decode transfer. imem_rvalid has no
// ready: every in-order response is consumed on the cycle it arrives.
module ifetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    ifetch_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        valid;
        logic        filled;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        misalign;
        logic [31:0] instr;
    } entry_t;

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            can_issue;
    logic            alloc;
    logic            fill;
    logic            drop;
    logic            pop;
    logic [CW-1:0]   unfilled;
    entry_t          head;

    always_comb begin
        // Registered count only: a pop cannot make room for an allocation in
        // the same cycle when the buffer is full.
        can_issue = !reset && !bus.flush && (count_q < CW'(DEPTH)) && (drop_cnt_q == '0);

        head      = entries_q[rd_ptr_q];
        alloc     = bus.pc_valid && can_issue && bus.imem_gnt;
        fill      = bus.imem_rvalid && (drop_cnt_q == '0);
        drop      = bus.imem_rvalid && (drop_cnt_q != '0);
        pop       = head.valid && head.filled && bus.dec_ready;

        unfilled = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && !entries_q[i].filled) begin
                unfilled = unfilled + CW'(1);
            end
        end

        entries_d  = entries_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (bus.flush) begin
            // Every still-unfilled request will produce one response that must
            // be discarded; a response arriving right now is discarded already.
            // drop_cnt_q is only nonzero when nothing is unfilled, so adding it
            // keeps back-to-back flushes consistent.
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid  = 1'b0;
                entries_d[i].filled = 1'b0;
            end
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = drop_cnt_q + unfilled - CW'(bus.imem_rvalid);
        end else begin
            // Allocate, fill and pop always target distinct entries: alloc hits
            // an empty slot, fill an unfilled one, pop a filled one.
            if (alloc) begin
                entries_d[wr_ptr_q].valid    = 1'b1;
                entries_d[wr_ptr_q].filled   = 1'b0;
                entries_d[wr_ptr_q].pc       = bus.pc_in;
                entries_d[wr_ptr_q].pc4      = bus.pc_in + 32'd4;
                entries_d[wr_ptr_q].misalign = (bus.pc_in[1:0] != 2'b00);
                wr_ptr_d                     = wr_ptr_q + PW'(1);
            end
            if (fill) begin
                entries_d[fill_ptr_q].instr  = bus.imem_rdata;
                entries_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d                   = fill_ptr_q + PW'(1);
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (pop) begin
                entries_d[rd_ptr_q].valid = 1'b0;
                rd_ptr_d                  = rd_ptr_q + PW'(1);
            end
            if (alloc && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !alloc) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            entries_q  <= entries_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.imem_req     = bus.pc_valid && can_issue;
    assign bus.pc_ready     = can_issue && bus.imem_gnt;
    assign bus.imem_addr    = {bus.pc_in[31:2], 2'b00};
    // dec_valid is deliberately not gated by flush; decode squashes on flush.
    assign bus.dec_valid    = head.valid && head.filled;
    assign bus.dec_instr    = head.instr;
    assign bus.dec_pc       = head.pc;
    assign bus.dec_pc4      = head.pc4;
    assign bus.dec_misalign = head.misalign;
endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    ifetch_if bus ();

    ifetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_fail = 0;

    // expected entry: {misalign, pc4, pc, instr}, in issue order
    logic [96:0] exp_q[$];
    // data the memory model still owes, in order (including responses to drop)
    logic [31:0] mem_q[$];
    int          ready_cnt = 0;   // leading exp_q entries whose response has arrived
    int          stale     = 0;   // responses still owed for flushed requests
    logic        last_grant = 1'b0;
    int          n_grants  = 0;
    int          n_pops    = 0;

    // stimulus knobs
    logic        mem_auto    = 1'b0;
    int          gnt_pct     = 100;
    int          rv_pct      = 100;
    logic        rdy_rand    = 1'b0;
    logic        use_fixed   = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;
    int          feed_n      = 0;
    int          feed_idx    = 0;
    logic [31:0] feed_base   = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (evaluated mid-cycle) ----------------
    logic        m_can;
    logic        m_grant;
    logic        m_pop;
    logic [31:0] m_data;
    logic [96:0] m_head;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_imem_req", 32'(bus.imem_req), 0);
            check("rst_pc_ready", 32'(bus.pc_ready), 0);
            exp_q.delete();
            mem_q.delete();
            ready_cnt  = 0;
            stale      = 0;
            last_grant = 1'b0;
        end else begin
            m_can = !bus.flush && (exp_q.size() < DEPTH) && (stale == 0);
            check("imem_req", 32'(bus.imem_req), 32'(bus.pc_valid && m_can));
            check("pc_ready", 32'(bus.pc_ready), 32'(m_can && bus.imem_gnt));
            if (bus.imem_req) check("imem_addr", bus.imem_addr, bus.pc_in & 32'hFFFF_FFFC);
            check("dec_valid", 32'(bus.dec_valid), 32'(ready_cnt > 0));
            if (ready_cnt > 0) begin
                m_head = exp_q[0];
                check("dec_instr", bus.dec_instr, m_head[31:0]);
                check("dec_pc", bus.dec_pc, m_head[63:32]);
                check("dec_pc4", bus.dec_pc4, m_head[95:64]);
                check("dec_misalign", 32'(bus.dec_misalign), 32'(m_head[96]));
            end

            m_grant    = bus.pc_valid && bus.pc_ready;
            m_pop      = (ready_cnt > 0) && bus.dec_ready && !bus.flush;
            last_grant = m_grant;

            if (bus.imem_rvalid) begin
                if (mem_q.size() == 0) check("orphan_response", 1, 0);
                else void'(mem_q.pop_front());
            end
            if (m_grant) begin
                n_grants++;
                m_data = use_fixed ? fixed_rdata : $urandom();
                mem_q.push_back(m_data);
            end

            if (bus.flush) begin
                stale = stale + (exp_q.size() - ready_cnt) - (bus.imem_rvalid ? 1 : 0);
                exp_q.delete();
                ready_cnt = 0;
            end else begin
                if (bus.imem_rvalid) begin
                    if (stale > 0) stale--;
                    else if (ready_cnt >= exp_q.size()) check("response_no_entry", 1, 0);
                    else ready_cnt++;
                end
                if (m_pop) begin
                    void'(exp_q.pop_front());
                    ready_cnt--;
                    n_pops++;
                end
                if (m_grant) begin
                    exp_q.push_back({(bus.pc_in[1:0] != 2'b00), bus.pc_in + 32'd4, bus.pc_in, m_data});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mem_set(input logic g, input logic rv);
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv && (mem_q.size() != 0);
        bus.imem_rdata  = bus.imem_rvalid ? mem_q[0] : $urandom();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_auto) mem_set($urandom_range(0, 99) < gnt_pct, $urandom_range(0, 99) < rv_pct);
        if (rdy_rand) bus.dec_ready = $urandom_range(0, 1);
        if (feed_n > 0) begin
            if (last_grant) feed_idx++;
            bus.pc_valid = (feed_idx < feed_n);
            bus.pc_in    = feed_base + 32'(feed_idx) * 32'd4;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic wait_dec(input string tag, input logic [31:0] exp_pc, input int budget);
        int k;
        k = 0;
        while (!bus.dec_valid && k < budget) begin
            tick();
            k++;
        end
        if (!bus.dec_valid) check({tag, "_timeout"}, 0, 1);
        else check(tag, bus.dec_pc, exp_pc);
    endtask

    task automatic single_fetch(input string tag);
        use_fixed    = 1'b1;
        fixed_rdata  = 32'h0050_0093;
        bus.dec_ready = 1'b0;
        bus.pc_in    = 32'h100;
        bus.pc_valid = 1'b1;
        mem_set(1'b1, 1'b0);
        tick();                                  // grant at T
        bus.pc_valid = 1'b0;
        mem_set(1'b0, 1'b1);                     // response at T+1
        check({tag, "_lat_t1"}, 32'(bus.dec_valid), 0);
        tick();                                  // now in T+2
        mem_set(1'b0, 1'b0);
        check({tag, "_valid"}, 32'(bus.dec_valid), 1);
        check({tag, "_instr"}, bus.dec_instr, 32'h0050_0093);
        check({tag, "_pc"}, bus.dec_pc, 32'h100);
        check({tag, "_pc4"}, bus.dec_pc4, 32'h104);
        check({tag, "_mis"}, 32'(bus.dec_misalign), 0);
        use_fixed     = 1'b0;
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        check({tag, "_popped"}, 32'(bus.dec_valid), 0);
    endtask

    task automatic drain(input string tag);
        int k;
        feed_n = 0;
        bus.pc_valid = 1'b0;
        bus.flush = 1'b0;
        rdy_rand = 1'b0;
        bus.dec_ready = 1'b1;
        mem_auto = 1'b1;
        rv_pct = 100;
        k = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_empty"}, 32'(exp_q.size() + mem_q.size()), 0);
        mem_auto = 1'b0;
        mem_set(1'b0, 1'b0);
        bus.dec_ready = 1'b0;
        tick();
    endtask

    // ---------------- test sequence ----------------
    int g0;
    int p0;

    initial begin
        reset = 1'b1;
        bus.pc_in = '0;
        bus.pc_valid = 1'b0;
        bus.flush = 1'b0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.dec_ready = 1'b0;
        do_reset(3);

        // reset state
        check("reset_dec_valid", 32'(bus.dec_valid), 0);
        check("reset_dec_pc", bus.dec_pc, 0);
        check("reset_dec_instr", bus.dec_instr, 0);
        check("reset_pc_ready", 32'(bus.pc_ready), 0);

        single_fetch("single");

        // backpressure: 6 PCs, decode stalled, only DEPTH grants
        g0 = n_grants;
        feed_base = 32'h0; feed_idx = 0; feed_n = 6;
        bus.pc_valid = 1'b1; bus.pc_in = 32'h0;
        mem_auto = 1'b1; gnt_pct = 100; rv_pct = 100;
        repeat (10) tick();
        check("bp_grants", 32'(n_grants - g0), DEPTH);
        check("bp_pc_ready", 32'(bus.pc_ready), 0);
        bus.dec_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_dec("bp_order", 32'(k) * 32'd4, 20);
            tick();
        end
        drain("bp");

        // variable latency over 20 PCs
        g0 = n_grants; p0 = n_pops;
        feed_base = 32'h1000; feed_idx = 0; feed_n = 20;
        bus.pc_valid = 1'b1; bus.pc_in = 32'h1000;
        mem_auto = 1'b1; gnt_pct = 40; rv_pct = 35; rdy_rand = 1'b1;
        for (int k = 0; k < 400 && (feed_idx < 20 || exp_q.size() != 0); k++) tick();
        drain("vl");
        check("vl_grants", 32'(n_grants - g0), 20);
        check("vl_pops", 32'(n_pops - p0), 20);

        // flush with requests in flight
        bus.pc_valid = 1'b1; bus.pc_in = 32'h300; mem_set(1'b1, 1'b0);
        tick(); bus.pc_in = 32'h304;
        tick(); bus.pc_in = 32'h308;
        tick();
        bus.pc_valid = 1'b0; mem_set(1'b0, 1'b1);
        tick();                                   // first response fills 0x300
        check("fl_head_ready", 32'(bus.dec_valid), 1);
        mem_set(1'b0, 1'b1); bus.flush = 1'b1;
        tick();                                   // flush + second response
        bus.flush = 1'b0; mem_set(1'b0, 1'b0);
        check("fl_dec_valid", 32'(bus.dec_valid), 0);
        check("fl_drop_cnt", 32'(dut.drop_cnt_q), 1);
        bus.pc_valid = 1'b1; bus.pc_in = 32'h200; mem_set(1'b1, 1'b0);
        check("fl_req_blocked", 32'(bus.imem_req), 0);
        tick();
        mem_set(1'b1, 1'b1);                      // last stale response dropped
        tick();
        check("fl_drop_done", 32'(dut.drop_cnt_q), 0);
        mem_set(1'b1, 1'b0);
        tick();                                   // 0x200 granted
        bus.pc_valid = 1'b0; mem_set(1'b0, 1'b1);
        tick();
        mem_set(1'b0, 1'b0);
        wait_dec("fl_new_pc", 32'h200, 5);
        drain("fl");

        // edge values
        bus.pc_valid = 1'b1; bus.pc_in = 32'hFFFF_FFFC; mem_set(1'b1, 1'b0);
        tick();
        bus.pc_valid = 1'b0; mem_set(1'b0, 1'b1);
        tick();
        mem_set(1'b0, 1'b0);
        wait_dec("edge_top_pc", 32'hFFFF_FFFC, 5);
        check("edge_pc4_wrap", bus.dec_pc4, 32'h0);
        drain("edge1");
        bus.pc_valid = 1'b1; bus.pc_in = 32'h102; mem_set(1'b0, 1'b0);
        #1;
        check("edge_addr_align", bus.imem_addr, 32'h100);
        mem_set(1'b1, 1'b0);
        tick();
        bus.pc_valid = 1'b0; mem_set(1'b0, 1'b1);
        tick();
        mem_set(1'b0, 1'b0);
        wait_dec("edge_mis_pc", 32'h102, 5);
        check("edge_misalign", 32'(bus.dec_misalign), 1);
        drain("edge2");

        // reset with 2 buffered and 1 in flight
        bus.pc_valid = 1'b1; bus.pc_in = 32'h400; mem_set(1'b1, 1'b0);
        tick(); bus.pc_in = 32'h404;
        tick(); bus.pc_in = 32'h408; mem_set(1'b1, 1'b1);
        tick(); bus.pc_valid = 1'b0; mem_set(1'b0, 1'b1);
        tick(); mem_set(1'b0, 1'b0);
        check("mid_buffered", 32'(bus.dec_valid), 1);
        do_reset(1);
        check("mid_rst_valid", 32'(bus.dec_valid), 0);
        check("mid_rst_pc", bus.dec_pc, 0);
        check("mid_rst_pc4", bus.dec_pc4, 0);
        check("mid_rst_instr", bus.dec_instr, 0);
        check("mid_rst_mis", 32'(bus.dec_misalign), 0);
        single_fetch("post_rst");

        // randomized traffic with occasional flush and reset
        mem_auto = 1'b1; gnt_pct = 70; rv_pct = 55; rdy_rand = 1'b1;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (!bus.pc_valid || last_grant) begin
                bus.pc_valid = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 3) == 0) bus.pc_in = $urandom();
                else bus.pc_in = bus.pc_in + 32'd4;
            end
            bus.flush = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
